// File: rtl/rrf_commit_unit_if.sv
// Rename/commit bundle between rename, execute, ARF and the RRF.
// Signal names match the RRF port list; widths follow the parameters.
interface rrf_commit_unit_if #(
    parameter int DATA_LEN = 32,
    parameter int REG_SEL  = 5,
    parameter int RRF_SEL  = 6
);
    logic                flush_i;
    logic                alloc_req_i;
    logic [REG_SEL-1:0]  alloc_dst_num_i;
    logic                alloc_grant_o;
    logic [RRF_SEL-1:0]  alloc_tag_o;
    logic [REG_SEL-1:0]  dst_num_setbusy_o;
    logic [RRF_SEL-1:0]  dst_rrftag_setbusy_o;
    logic                dst_en_setbusy_o;
    logic                wb_en_i;
    logic [RRF_SEL-1:0]  wb_tag_i;
    logic [DATA_LEN-1:0] wb_data_i;
    logic [RRF_SEL-1:0]  rs1_tag_i;
    logic [RRF_SEL-1:0]  rs2_tag_i;
    logic                rs1_valid_o;
    logic                rs2_valid_o;
    logic [DATA_LEN-1:0] rs1_data_o;
    logic [DATA_LEN-1:0] rs2_data_o;
    logic                completed_we_o;
    logic [REG_SEL-1:0]  completed_dst_num_o;
    logic [RRF_SEL-1:0]  completed_dst_rrftag_o;
    logic [DATA_LEN-1:0] from_rrfdata_o;
    logic                full_o;
    logic                empty_o;

    modport slave (
        input  flush_i, alloc_req_i, alloc_dst_num_i,
        input  wb_en_i, wb_tag_i, wb_data_i,
        input  rs1_tag_i, rs2_tag_i,
        output alloc_grant_o, alloc_tag_o,
        output dst_num_setbusy_o, dst_rrftag_setbusy_o,
        output dst_en_setbusy_o,
        output rs1_valid_o, rs2_valid_o,
        output rs1_data_o, rs2_data_o,
        output completed_we_o, completed_dst_num_o,
        output completed_dst_rrftag_o, from_rrfdata_o,
        output full_o, empty_o
    );

    modport master (
        output flush_i, alloc_req_i, alloc_dst_num_i,
        output wb_en_i, wb_tag_i, wb_data_i,
        output rs1_tag_i, rs2_tag_i,
        input  alloc_grant_o, alloc_tag_o,
        input  dst_num_setbusy_o, dst_rrftag_setbusy_o,
        input  dst_en_setbusy_o,
        input  rs1_valid_o, rs2_valid_o,
        input  rs1_data_o, rs2_data_o,
        input  completed_we_o, completed_dst_num_o,
        input  completed_dst_rrftag_o, from_rrfdata_o,
        input  full_o, empty_o
    );
endinterface

// File: rtl/rrf_commit_unit.sv
// Rename register file: in-order tag allocation, writeback by tag,
// operand lookup with same-cycle forwarding and in-order commit to the ARF.
module rrf_commit_unit #(
    parameter int DATA_LEN = 32,
    parameter int REG_SEL  = 5,
    parameter int RRF_SEL  = 6,
    parameter int RRF_NUM  = 64
) (
    input  logic              clk_i,
    input  logic              reset_i,
    rrf_commit_unit_if.slave  rrf
);
    localparam logic [RRF_SEL:0] CNT_FULL = (RRF_SEL+1)'(RRF_NUM);

    logic [RRF_SEL-1:0]  head_q, head_d;
    logic [RRF_SEL-1:0]  tail_q, tail_d;
    logic [RRF_SEL:0]    count_q, count_d;
    logic [RRF_NUM-1:0]  valid_q, valid_d;
    logic [REG_SEL-1:0]  dst_q  [RRF_NUM];
    logic [DATA_LEN-1:0] data_q [RRF_NUM];

    logic                we_q, we_d;
    logic [REG_SEL-1:0]  cnum_q, cnum_d;
    logic [RRF_SEL-1:0]  ctag_q, ctag_d;
    logic [DATA_LEN-1:0] cdata_q, cdata_d;

    logic               full, empty;
    logic               grant, wb_hit, commit;
    logic [RRF_SEL-1:0] wb_off;
    logic               fwd1, fwd2;

    assign full   = (count_q == CNT_FULL);
    assign empty  = (count_q == '0);
    assign grant  = rrf.alloc_req_i & ~full & ~rrf.flush_i;
    assign wb_off = rrf.wb_tag_i - head_q;
    // Modular distance from head tells whether the tag is still in flight
    assign wb_hit = rrf.wb_en_i & ~rrf.flush_i
                  & ({1'b0, wb_off} < count_q);
    assign commit = ~rrf.flush_i & ~empty & valid_q[head_q];

    assign fwd1 = rrf.wb_en_i & (rrf.wb_tag_i == rrf.rs1_tag_i);
    assign fwd2 = rrf.wb_en_i & (rrf.wb_tag_i == rrf.rs2_tag_i);

    assign rrf.alloc_grant_o        = grant;
    assign rrf.alloc_tag_o          = tail_q;
    assign rrf.dst_en_setbusy_o     = grant;
    assign rrf.dst_num_setbusy_o    = rrf.alloc_dst_num_i;
    assign rrf.dst_rrftag_setbusy_o = tail_q;
    assign rrf.full_o               = full;
    assign rrf.empty_o              = empty;

    assign rrf.rs1_valid_o = fwd1 | valid_q[rrf.rs1_tag_i];
    assign rrf.rs2_valid_o = fwd2 | valid_q[rrf.rs2_tag_i];
    assign rrf.rs1_data_o  = fwd1 ? rrf.wb_data_i
                                  : data_q[rrf.rs1_tag_i];
    assign rrf.rs2_data_o  = fwd2 ? rrf.wb_data_i
                                  : data_q[rrf.rs2_tag_i];

    assign rrf.completed_we_o         = we_q;
    assign rrf.completed_dst_num_o    = cnum_q;
    assign rrf.completed_dst_rrftag_o = ctag_q;
    assign rrf.from_rrfdata_o         = cdata_q;

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        valid_d = valid_q;
        we_d    = 1'b0;
        cnum_d  = cnum_q;
        ctag_d  = ctag_q;
        cdata_d = cdata_q;
        if (rrf.flush_i) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
            valid_d = '0;
        end else begin
            if (grant) begin
                valid_d[tail_q] = 1'b0;
                tail_d          = tail_q + RRF_SEL'(1);
            end
            if (wb_hit) begin
                valid_d[rrf.wb_tag_i] = 1'b1;
            end
            if (commit) begin
                we_d    = 1'b1;
                cnum_d  = dst_q[head_q];
                ctag_d  = head_q;
                cdata_d = data_q[head_q];
                head_d  = head_q + RRF_SEL'(1);
            end
            count_d = count_q + (RRF_SEL+1)'(grant)
                              - (RRF_SEL+1)'(commit);
        end
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            valid_q <= '0;
            we_q    <= 1'b0;
            cnum_q  <= '0;
            ctag_q  <= '0;
            cdata_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            valid_q <= valid_d;
            we_q    <= we_d;
            cnum_q  <= cnum_d;
            ctag_q  <= ctag_d;
            cdata_q <= cdata_d;
        end
    end

    // Payload storage needs no reset; valid bits gate every use
    always_ff @(posedge clk_i) begin
        if (grant) begin
            dst_q[tail_q] <= rrf.alloc_dst_num_i;
        end
        if (wb_hit) begin
            data_q[rrf.wb_tag_i] <= rrf.wb_data_i;
        end
    end
endmodule
